aqed_multi_pair_checker: RTL and testbench
==========================================

# aqed_multi_pair_checker

Parametrised A-QED functional-consistency checker for the memory-core verification harness. It watches the in-order read/write request stream into the memory core and the read-response stream out of it. It tracks up to NUM_PAIRS original/duplicate read pairs at once and flags any pair whose two responses differ. It generalises the single-pair checker to configurable widths and multiple concurrent pairs, and adds write-hazard invalidation, a sticky failure flag and occupancy reporting.

## Interface
Parameters:
- DATA_WIDTH, 16: request write data and response data width.
- ADDR_WIDTH, 16: request address width.
- NUM_PAIRS, 4: number of concurrent orig/dup tracking slots, ≥1.
- SEQ_WIDTH, 8: read/response sequence counter width. Outstanding reads must stay below 2^SEQ_WIDTH.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high. Clears all state.
- flush, input, 1: synchronous clear of all slots and both counters; the sticky flag is kept.
- req_valid, input, 1: a request is issued to the DUT this cycle.
- req_wen, input, 1: 1 = write, 0 = read.
- req_addr, input, ADDR_WIDTH: request address.
- mark_orig, input, 1: tag this read as an original (driven freely by the solver).
- mark_dup, input, 1: tag this read as a duplicate.
- rsp_valid, input, 1: a read response is returned this cycle, in request order.
- rsp_data, input, DATA_WIDTH: response data.
- qed_done, output, 1: one-cycle pulse when a pair completes.
- qed_check, output, 1: valid with qed_done; 1 means the two responses matched.
- qed_slot, output, clog2(NUM_PAIRS) (min 1): index of the slot that completed.
- hazard_drop, output, 1: one-cycle pulse when a slot is invalidated by a write.
- qed_fail_sticky, output, 1: set on the first mismatch; cleared only by reset.
- pairs_active, output, clog2(NUM_PAIRS+1): number of non-FREE slots.

## Operation
- Counters:
  - rd_seq increments on every read request.
  - rsp_seq increments on every rsp_valid.
  - Both wrap modulo 2^SEQ_WIDTH and are compared by equality only.
- Each slot holds state, addr, orig_seq, dup_seq, orig_data and orig_got.
- Slot states and transitions:
  - FREE → ORIG: a read with mark_orig that does not qualify as a dup (see priority rule) allocates the lowest-index FREE slot. It captures req_addr and the current rd_seq. If no slot is FREE, the mark is ignored.
  - ORIG → PAIR: a read with mark_dup whose address equals the slot addr. The lowest-index matching ORIG slot is chosen. It captures the current rd_seq as dup_seq.
  - ORIG → FREE: a write to the slot addr. hazard_drop pulses. Every matching ORIG slot is dropped in the same cycle.
  - PAIR ignores writes, because both reads are already issued.
  - PAIR → FREE: the response whose rsp_seq equals dup_seq arrives. The checker compares rsp_data with orig_data.
- Orig response capture: when rsp_seq == orig_seq in ORIG or PAIR, store rsp_data into orig_data and set orig_got.
- Priority rule: if mark_orig and mark_dup are both set, dup wins when a matching ORIG slot exists; otherwise the read is treated as orig.
- A read with neither mark only advances rd_seq. Marks on writes are ignored.
- Responses are in order and at most one arrives per cycle, so at most one pair completes per cycle.
- The orig response always precedes the dup response. A dup response arriving with orig_got=0 is a protocol violation; it is reported as qed_check=0.
- The DUT response latency is at least 1 cycle, so a response never belongs to a request issued in the same cycle.
- In one cycle, a request and a response are processed independently, each against the pre-update state.
- A slot freed this cycle is allocatable next cycle, not this cycle.

## Timing
- All outputs are registered. Reset value is 0 for every output.
- qed_done, qed_check and qed_slot assert in the cycle after the dup rsp_valid.
- hazard_drop asserts in the cycle after the write.
- qed_fail_sticky rises in the same cycle as qed_done with qed_check=0.
- pairs_active reflects slot state one cycle after the causing event.
- Reset or flush in the middle of an operation:
  - All slots go FREE and both counters go to 0 on the next edge.
  - A completion pending in the same cycle is discarded.
  - Reset also clears qed_fail_sticky; flush does not.

## Test plan
- Single pair, matching data:
  - Stimulus: read A=0x10 with mark_orig (rsp 0xBEEF at +2); idle 3 cycles; read 0x10 with mark_dup (rsp 0xBEEF).
  - Response: qed_done=1, qed_check=1, qed_slot=0 one cycle after the dup response; pairs_active goes 1 → 0.
- Mismatch:
  - Stimulus: same sequence, but the dup response is 0xBEEE.
  - Response: qed_check=0 and qed_fail_sticky=1, which stays high through 10 more idle cycles and a flush.
- Write hazard:
  - Stimulus: orig read 0x20; write 0x20; dup read 0x20.
  - Response: hazard_drop pulses after the write; no qed_done; pairs_active returns to 0.
- Multiple pairs (NUM_PAIRS=4):
  - Stimulus: orig reads to 0x1, 0x2, 0x3, 0x4, then a fifth orig read to 0x5; then dup reads in order 0x3, 0x1.
  - Response: the fifth orig is ignored (pairs_active=4); completions report qed_slot=2, then 0.
- Simultaneous marks and wrap-around:
  - Stimulus: mark_orig and mark_dup on a read to an address with an open ORIG slot; separately, 300 unmarked reads between orig and dup with SEQ_WIDTH=8 and ≤255 reads outstanding.
  - Response: the first read closes the pair. In the second case the pair still completes correctly.
- Reset mid-pair:
  - Stimulus: assert reset the cycle before the dup response.
  - Response: no qed_done; all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/aqed_multi_pair_checker_if.sv
// aqed_multi_pair_checker_if: request/response stream and check-result bundle
// shared between the memory-core harness and the A-QED pair checker.
interface aqed_multi_pair_checker_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_PAIRS  = 4
);
    localparam int SLOT_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int CNT_W  = $clog2(NUM_PAIRS + 1);

    logic                  req_valid;
    logic                  req_wen;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  mark_orig;
    logic                  mark_dup;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  qed_done;
    logic                  qed_check;
    logic [SLOT_W-1:0]     qed_slot;
    logic                  hazard_drop;
    logic                  qed_fail_sticky;
    logic [CNT_W-1:0]      pairs_active;

    modport master (
        output req_valid, req_wen, req_addr, mark_orig, mark_dup, rsp_valid, rsp_data,
        input  qed_done, qed_check, qed_slot, hazard_drop, qed_fail_sticky, pairs_active
    );

    modport slave (
        input  req_valid, req_wen, req_addr, mark_orig, mark_dup, rsp_valid, rsp_data,
        output qed_done, qed_check, qed_slot, hazard_drop, qed_fail_sticky, pairs_active
    );
endinterface

// File: rtl/aqed_multi_pair_checker.sv
// aqed_multi_pair_checker: tracks up to NUM_PAIRS orig/dup read pairs by sequence
// number and flags any pair whose two in-order responses differ.
module aqed_multi_pair_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_PAIRS  = 4,
    parameter int SEQ_WIDTH  = 8
) (
    input logic                      clk,
    input logic                      reset,
    input logic                      flush,
    aqed_multi_pair_checker_if.slave bus
);
    localparam int SLOT_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int CNT_W  = $clog2(NUM_PAIRS + 1);
    localparam logic [1:0] FREE = 2'd0, ORIG = 2'd1, PAIR = 2'd2;

    logic [1:0]            st_q    [NUM_PAIRS];
    logic [1:0]            st_d    [NUM_PAIRS];
    logic [ADDR_WIDTH-1:0] addr_q  [NUM_PAIRS];
    logic [ADDR_WIDTH-1:0] addr_d  [NUM_PAIRS];
    logic [SEQ_WIDTH-1:0]  oseq_q  [NUM_PAIRS];
    logic [SEQ_WIDTH-1:0]  oseq_d  [NUM_PAIRS];
    logic [SEQ_WIDTH-1:0]  dseq_q  [NUM_PAIRS];
    logic [SEQ_WIDTH-1:0]  dseq_d  [NUM_PAIRS];
    logic [DATA_WIDTH-1:0] odata_q [NUM_PAIRS];
    logic [DATA_WIDTH-1:0] odata_d [NUM_PAIRS];
    logic                  ogot_q  [NUM_PAIRS];
    logic                  ogot_d  [NUM_PAIRS];
    logic [SEQ_WIDTH-1:0]  rd_seq_q, rd_seq_d, rsp_seq_q, rsp_seq_d;
    logic                  done_q, done_d, chk_q, chk_d, haz_q, haz_d, sticky_q, sticky_d;
    logic [SLOT_W-1:0]     slot_q, slot_d, dup_idx, free_idx;
    logic [CNT_W-1:0]      act_q, act_d;
    logic                  is_rd, is_wr, dup_hit, free_hit;

    always_comb begin
        st_d      = st_q;
        addr_d    = addr_q;
        oseq_d    = oseq_q;
        dseq_d    = dseq_q;
        odata_d   = odata_q;
        ogot_d    = ogot_q;
        is_rd     = bus.req_valid & ~bus.req_wen;
        is_wr     = bus.req_valid & bus.req_wen;
        rd_seq_d  = rd_seq_q + SEQ_WIDTH'(is_rd);
        rsp_seq_d = rsp_seq_q + SEQ_WIDTH'(bus.rsp_valid);
        dup_hit   = 1'b0;
        dup_idx   = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        done_d    = 1'b0;
        chk_d     = 1'b0;
        slot_d    = '0;
        haz_d     = 1'b0;
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
            if (st_q[i] == ORIG && addr_q[i] == bus.req_addr) begin
                dup_hit = 1'b1;
                dup_idx = SLOT_W'(i);
            end
            if (st_q[i] == FREE) begin
                free_hit = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
        for (int i = 0; i < NUM_PAIRS; i++) begin
            // Only the first orig response is kept, so a wrapped rsp_seq cannot overwrite it.
            if (bus.rsp_valid && st_q[i] != FREE && !ogot_q[i] && rsp_seq_q == oseq_q[i]) begin
                odata_d[i] = bus.rsp_data;
                ogot_d[i]  = 1'b1;
            end
            if (bus.rsp_valid && st_q[i] == PAIR && rsp_seq_q == dseq_q[i]) begin
                st_d[i] = FREE;
                done_d  = 1'b1;
                chk_d   = ogot_q[i] && odata_q[i] == bus.rsp_data;
                slot_d  = SLOT_W'(i);
            end
            if (is_wr && st_q[i] == ORIG && addr_q[i] == bus.req_addr) begin
                st_d[i] = FREE;
                haz_d   = 1'b1;
            end
        end
        if (is_rd && bus.mark_dup && dup_hit) begin
            st_d[dup_idx]   = PAIR;
            dseq_d[dup_idx] = rd_seq_q;
        end else if (is_rd && bus.mark_orig && free_hit) begin
            st_d[free_idx]   = ORIG;
            addr_d[free_idx] = bus.req_addr;
            oseq_d[free_idx] = rd_seq_q;
            ogot_d[free_idx] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NUM_PAIRS; i++) st_d[i] = FREE;
            rd_seq_d  = '0;
            rsp_seq_d = '0;
            done_d    = 1'b0;
            chk_d     = 1'b0;
            slot_d    = '0;
            haz_d     = 1'b0;
        end
        sticky_d = sticky_q | (done_d & ~chk_d);
        act_d    = '0;
        for (int i = 0; i < NUM_PAIRS; i++) act_d = act_d + CNT_W'(st_d[i] != FREE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                st_q[i]    <= FREE;
                addr_q[i]  <= '0;
                oseq_q[i]  <= '0;
                dseq_q[i]  <= '0;
                odata_q[i] <= '0;
                ogot_q[i]  <= 1'b0;
            end
            rd_seq_q  <= '0;
            rsp_seq_q <= '0;
            done_q    <= 1'b0;
            chk_q     <= 1'b0;
            slot_q    <= '0;
            haz_q     <= 1'b0;
            sticky_q  <= 1'b0;
            act_q     <= '0;
        end else begin
            st_q      <= st_d;
            addr_q    <= addr_d;
            oseq_q    <= oseq_d;
            dseq_q    <= dseq_d;
            odata_q   <= odata_d;
            ogot_q    <= ogot_d;
            rd_seq_q  <= rd_seq_d;
            rsp_seq_q <= rsp_seq_d;
            done_q    <= done_d;
            chk_q     <= chk_d;
            slot_q    <= slot_d;
            haz_q     <= haz_d;
            sticky_q  <= sticky_d;
            act_q     <= act_d;
        end
    end

    assign bus.qed_done        = done_q;
    assign bus.qed_check       = chk_q;
    assign bus.qed_slot        = slot_q;
    assign bus.hazard_drop     = haz_q;
    assign bus.qed_fail_sticky = sticky_q;
    assign bus.pairs_active    = act_q;
endmodule

// File: tb/tb_aqed_multi_pair_checker.sv
// tb_aqed_multi_pair_checker: directed vectors against a 2-cycle-latency
// response model feeding the checker.
module tb_aqed_multi_pair_checker;
    logic clk, reset, flush;
    int   n_chk = 0, n_err = 0;

    aqed_multi_pair_checker_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_PAIRS(4)) bus ();

    aqed_multi_pair_checker #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_PAIRS(4), .SEQ_WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic rv, wen; logic [15:0] a; logic mo, md; logic [15:0] d; logic fl, rs;
        logic e_done, e_chk; logic [1:0] e_slot; logic e_haz, e_stk; logic [2:0] e_act;
    } vec_t;
    vec_t vq[$];

    logic        p0_v = 1'b0, p1_v = 1'b0;
    logic [15:0] p0_d = '0, p1_d = '0;

    task automatic add(input logic rv, wen, input logic [15:0] a, input logic mo, md,
                       input logic [15:0] d, input logic fl, rs, e_done, e_chk,
                       input logic [1:0] e_slot, input logic e_haz, e_stk, input logic [2:0] e_act);
        vec_t v;
        v = '{rv, wen, a, mo, md, d, fl, rs, e_done, e_chk, e_slot, e_haz, e_stk, e_act};
        vq.push_back(v);
    endtask

    task automatic idle(input int n, input logic stk, input logic [2:0] act);
        for (int i = 0; i < n; i++) add(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, 2'd0, 0, stk, act);
    endtask

    // Reads return their data two cycles later, in order.
    task automatic step(input logic rv, wen, input logic [15:0] a, input logic mo, md,
                        input logic [15:0] d, input logic fl, rs);
        bus.req_valid = rv;
        bus.req_wen   = wen;
        bus.req_addr  = a;
        bus.mark_orig = mo;
        bus.mark_dup  = md;
        bus.rsp_valid = p1_v;
        bus.rsp_data  = p1_d;
        flush         = fl;
        reset         = rs;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            p0_v = 1'b0;
            p1_v = 1'b0;
        end else begin
            p1_v = p0_v;
            p1_d = p0_d;
            p0_v = rv & ~wen;
            p0_d = d;
        end
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic done, chk_v, input logic [1:0] slot,
                           input logic haz, stk, input logic [2:0] act);
        chk({n, ".done"}, 16'(bus.qed_done), 16'(done));
        chk({n, ".check"}, 16'(bus.qed_check), 16'(chk_v));
        chk({n, ".slot"}, 16'(bus.qed_slot), 16'(slot));
        chk({n, ".hazard"}, 16'(bus.hazard_drop), 16'(haz));
        chk({n, ".sticky"}, 16'(bus.qed_fail_sticky), 16'(stk));
        chk({n, ".active"}, 16'(bus.pairs_active), 16'(act));
    endtask

    initial begin
        logic got;
        bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = 0; bus.mark_orig = 0;
        bus.mark_dup = 0; bus.rsp_valid = 0; bus.rsp_data = 0; flush = 0; reset = 1;
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 0, 0, 2'd0, 0, 0, 3'd0);
        // single matching pair
        add(1, 0, 16'h10, 1, 0, 16'hBEEF, 0, 0, 0, 0, 2'd0, 0, 0, 3'd1);
        idle(3, 0, 3'd1);
        add(1, 0, 16'h10, 0, 1, 16'hBEEF, 0, 0, 0, 0, 2'd0, 0, 0, 3'd1);
        idle(1, 0, 3'd1);
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 2'd0, 0, 0, 3'd0);
        idle(1, 0, 3'd0);
        // mismatch, sticky survives idle and flush
        add(1, 0, 16'h10, 1, 0, 16'hBEEF, 0, 0, 0, 0, 2'd0, 0, 0, 3'd1);
        idle(3, 0, 3'd1);
        add(1, 0, 16'h10, 0, 1, 16'hBEEE, 0, 0, 0, 0, 2'd0, 0, 0, 3'd1);
        idle(1, 0, 3'd1);
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 0, 2'd0, 0, 1, 3'd0);
        idle(10, 1, 3'd0);
        add(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 0, 2'd0, 0, 1, 3'd0);
        // write hazard
        add(1, 0, 16'h20, 1, 0, 16'h1234, 0, 0, 0, 0, 2'd0, 0, 1, 3'd1);
        add(1, 1, 16'h20, 0, 0, 16'h0, 0, 0, 0, 0, 2'd0, 1, 1, 3'd0);
        add(1, 0, 16'h20, 0, 1, 16'h1234, 0, 0, 0, 0, 2'd0, 0, 1, 3'd0);
        idle(3, 1, 3'd0);
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 0, 0, 2'd0, 0, 0, 3'd0);
        // four slots fill, fifth orig ignored, out-of-order dups
        add(1, 0, 16'h1, 1, 0, 16'hA1, 0, 0, 0, 0, 2'd0, 0, 0, 3'd1);
        add(1, 0, 16'h2, 1, 0, 16'hA2, 0, 0, 0, 0, 2'd0, 0, 0, 3'd2);
        add(1, 0, 16'h3, 1, 0, 16'hA3, 0, 0, 0, 0, 2'd0, 0, 0, 3'd3);
        add(1, 0, 16'h4, 1, 0, 16'hA4, 0, 0, 0, 0, 2'd0, 0, 0, 3'd4);
        add(1, 0, 16'h5, 1, 0, 16'hA5, 0, 0, 0, 0, 2'd0, 0, 0, 3'd4);
        add(1, 0, 16'h3, 0, 1, 16'hA3, 0, 0, 0, 0, 2'd0, 0, 0, 3'd4);
        add(1, 0, 16'h1, 0, 1, 16'hA1, 0, 0, 0, 0, 2'd0, 0, 0, 3'd4);
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 2'd2, 0, 0, 3'd3);
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 2'd0, 0, 0, 3'd2);
        idle(1, 0, 3'd2);
        // both marks: dup wins on open slot, orig otherwise
        add(1, 0, 16'h2, 1, 1, 16'hA2, 0, 0, 0, 0, 2'd0, 0, 0, 3'd2);
        idle(1, 0, 3'd2);
        add(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 2'd1, 0, 0, 3'd1);
        add(1, 0, 16'h9, 1, 1, 16'h55, 0, 0, 0, 0, 2'd0, 0, 0, 3'd2);

        foreach (vq[k]) begin
            step(vq[k].rv, vq[k].wen, vq[k].a, vq[k].mo, vq[k].md, vq[k].d, vq[k].fl, vq[k].rs);
            chk_all($sformatf("vec%0d", k), vq[k].e_done, vq[k].e_chk, vq[k].e_slot,
                    vq[k].e_haz, vq[k].e_stk, vq[k].e_act);
        end

        // sequence-number wrap: 300 unmarked reads between orig and dup
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
        step(1, 0, 16'h40, 1, 0, 16'hCAFE, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 16'(i + 16'h100), 0, 0, 16'(i), 0, 0);
        step(1, 0, 16'h40, 0, 1, 16'hCAFE, 0, 0);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
            got = bus.qed_done;
        end
        chk("wrap.done", 16'(got), 16'd1);
        chk("wrap.check", 16'(bus.qed_check), 16'd1);
        chk("wrap.slot", 16'(bus.qed_slot), 16'd0);
        chk("wrap.active", 16'(bus.pairs_active), 16'd0);

        // reset the cycle before the dup response
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
        step(1, 0, 16'h50, 1, 0, 16'h77, 0, 0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        step(1, 0, 16'h50, 0, 1, 16'h77, 0, 0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 1);
        chk_all("rst_mid", 0, 0, 2'd0, 0, 0, 3'd0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        chk_all("rst_after", 0, 0, 2'd0, 0, 0, 3'd0);

        // flush in the same cycle as a mismatching dup response discards it
        step(1, 0, 16'h60, 1, 0, 16'h11, 0, 0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        step(1, 0, 16'h60, 0, 1, 16'h22, 0, 0);
        chk("flush_pre.active", 16'(bus.pairs_active), 16'd1);
        step(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0, 16'h0, 1, 0);
        chk_all("flush_cmp", 0, 0, 2'd0, 0, 0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
